// File: rtl/add_seq_arb.sv
// Two-requester add/sub unit that arbitrates round-robin and computes the
// result one nibble per cycle on a single shared 4-bit carry-lookahead adder.

module add_seq_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [3:1] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s    = p ^ {c[3], c[2], c[1], ci};
endmodule

// state | meaning
// IDLE  | waiting for a request; grant and latch operands on any valid
// RUN   | one nibble per cycle through the shared adder, nibble 0 first
// DONE  | result presented until the consumer takes it
module add_seq_arb #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req0_valid,
  input  logic [4*NIBBLES-1:0] i_req0_a,
  input  logic [4*NIBBLES-1:0] i_req0_b,
  input  logic                 i_req0_sub,
  output logic                 o_req0_ready,
  input  logic                 i_req1_valid,
  input  logic [4*NIBBLES-1:0] i_req1_a,
  input  logic [4*NIBBLES-1:0] i_req1_b,
  input  logic                 i_req1_sub,
  output logic                 o_req1_ready,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic                 o_rsp_id,
  output logic [4*NIBBLES-1:0] o_rsp_s,
  output logic                 o_rsp_c,
  output logic                 o_rsp_v,
  output logic                 o_busy
);
  localparam int W = 4 * NIBBLES;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [2:0] LAST_NIB = 3'(NIBBLES - 1);

  logic [1:0]   state;
  logic [2:0]   nib;
  logic         carry;
  logic         rsp_id;
  logic         prio;
  logic [W-1:0] a_reg, b_reg, s_reg;

  logic         grant0, grant1;
  logic         sel_sub;
  logic [W-1:0] sel_a, sel_b;
  logic [4:0]   sh;
  logic [3:0]   a_nib, b_nib, sum_nib;
  logic         cout;
  logic [W-1:0] nib_mask, sum_ins;

  // prio = 1 favours requester 1 on a tie; a lone valid wins regardless
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !i_rst) begin
      if (i_req0_valid && (!i_req1_valid || !prio))
        grant0 = 1'b1;
      else if (i_req1_valid)
        grant1 = 1'b1;
    end
  end

  assign sel_a   = grant1 ? i_req1_a   : i_req0_a;
  assign sel_b   = grant1 ? i_req1_b   : i_req0_b;
  assign sel_sub = grant1 ? i_req1_sub : i_req0_sub;

  assign sh       = {nib, 2'b00};
  assign a_nib    = 4'(a_reg >> sh);
  assign b_nib    = 4'(b_reg >> sh);
  assign nib_mask = W'(4'hF) << sh;
  assign sum_ins  = W'(sum_nib) << sh;

  add_seq_cla4 u_cla (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .s  (sum_nib),
    .co (cout)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      nib    <= 3'd0;
      carry  <= 1'b0;
      rsp_id <= 1'b0;
      prio   <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      s_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            state  <= RUN;
            nib    <= 3'd0;
            a_reg  <= sel_a;
            b_reg  <= sel_b ^ {W{sel_sub}};
            carry  <= sel_sub;
            rsp_id <= grant1;
            prio   <= grant0;
          end
        end
        RUN: begin
          s_reg <= (s_reg & ~nib_mask) | sum_ins;
          carry <= cout;
          if (nib == LAST_NIB) begin
            state <= DONE;
            nib   <= 3'd0;
          end else begin
            nib <= nib + 3'd1;
          end
        end
        DONE: begin
          if (i_rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;
  assign o_rsp_valid  = (state == DONE);
  assign o_busy       = (state != IDLE);
  assign o_rsp_id     = rsp_id;
  assign o_rsp_s      = s_reg;
  assign o_rsp_c      = carry;
  // b_reg already holds the inverted operand for subtraction
  assign o_rsp_v      = (a_reg[W-1] == b_reg[W-1]) & (s_reg[W-1] != a_reg[W-1]);
endmodule

// File: tb/tb_add_seq_arb.sv
// Bench for add_seq_arb: single-threaded stimulus with a scoreboard queue
// filled at each grant and drained as responses are taken.

module tb_add_seq_arb;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic         i_req0_valid = 1'b0, i_req0_sub = 1'b0;
  logic [W-1:0] i_req0_a = '0, i_req0_b = '0;
  logic         i_req1_valid = 1'b0, i_req1_sub = 1'b0;
  logic [W-1:0] i_req1_a = '0, i_req1_b = '0;
  logic         i_rsp_ready = 1'b1;
  logic         o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_id;
  logic [W-1:0] o_rsp_s;
  logic         o_rsp_c, o_rsp_v, o_busy;

  add_seq_arb #(.NIBBLES(NIBBLES)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .i_req0_a     (i_req0_a),
    .i_req0_b     (i_req0_b),
    .i_req0_sub   (i_req0_sub),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_a     (i_req1_a),
    .i_req1_b     (i_req1_b),
    .i_req1_sub   (i_req1_sub),
    .o_req1_ready (o_req1_ready),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_s      (o_rsp_s),
    .o_rsp_c      (o_rsp_c),
    .o_rsp_v      (o_rsp_v),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic         id;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  logic         grant_log[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           xfer_cyc = 0;
  logic         acc0, acc1;
  logic         prev_rv = 1'b0;
  logic         held = 1'b0;
  logic [W-1:0] hold_s;
  logic         hold_c, hold_v, hold_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input int acc);
    exp_t m;
    m.id  = id;
    m.acc = acc;
    if (!sub) begin
      {m.c, m.s} = {1'b0, a} + {1'b0, b};
      m.v = (a[W-1] == b[W-1]) && (m.s[W-1] != a[W-1]);
    end else begin
      m.s = a - b;
      m.c = (a >= b);
      m.v = (a[W-1] != b[W-1]) && (m.s[W-1] != a[W-1]);
    end
    return m;
  endfunction

  task automatic monitor_step();
    exp_t e;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (i_rst) begin
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("rst_ready", 32'({o_req0_ready, o_req1_ready}), 32'd0);
      sb.delete();
      prev_rv = 1'b0;
      held = 1'b0;
    end else begin
      chk("double_grant", 32'(o_req0_ready & o_req1_ready), 32'd0);
      if (o_busy) chk("ready_while_busy", 32'({o_req0_ready, o_req1_ready}), 32'd0);
      if (o_rsp_valid) begin
        chk("valid_implies_busy", 32'(o_busy), 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          if (!prev_rv) chk("latency", 32'(cyc - sb[0].acc), 32'(NIBBLES + 1));
          if (held) begin
            chk("hold_s", 32'(o_rsp_s), 32'(hold_s));
            chk("hold_c", 32'(o_rsp_c), 32'(hold_c));
            chk("hold_v", 32'(o_rsp_v), 32'(hold_v));
            chk("hold_id", 32'(o_rsp_id), 32'(hold_id));
          end
          if (i_rsp_ready) begin
            e = sb.pop_front();
            chk("rsp_id", 32'(o_rsp_id), 32'(e.id));
            chk("rsp_s", 32'(o_rsp_s), 32'(e.s));
            chk("rsp_c", 32'(o_rsp_c), 32'(e.c));
            chk("rsp_v", 32'(o_rsp_v), 32'(e.v));
            held = 1'b0;
            xfer_cyc = cyc;
          end else begin
            held = 1'b1;
            hold_s = o_rsp_s;
            hold_c = o_rsp_c;
            hold_v = o_rsp_v;
            hold_id = o_rsp_id;
          end
        end
      end
      prev_rv = o_rsp_valid;
      if (i_req0_valid && o_req0_ready) begin
        sb.push_back(model(1'b0, i_req0_a, i_req0_b, i_req0_sub, cyc));
        grant_log.push_back(1'b0);
        acc0 = 1'b1;
        acc_cyc = cyc;
      end
      if (i_req1_valid && o_req1_ready) begin
        sb.push_back(model(1'b1, i_req1_a, i_req1_b, i_req1_sub, cyc));
        grant_log.push_back(1'b1);
        acc1 = 1'b1;
        acc_cyc = cyc;
      end
    end
  endtask

  // inputs change 1ns after a rising edge; outputs are observed on the falling edge
  task automatic tick();
    @(negedge i_clk);
    monitor_step();
    @(posedge i_clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic got;
    got = 1'b0;
    if (!id) begin
      i_req0_valid = 1'b1; i_req0_a = a; i_req0_b = b; i_req0_sub = sub;
    end else begin
      i_req1_valid = 1'b1; i_req1_a = a; i_req1_b = b; i_req1_sub = sub;
    end
    for (int i = 0; i < 60; i++) begin
      tick();
      if (id ? acc1 : acc0) begin
        got = 1'b1;
        break;
      end
    end
    // scramble operands after acceptance; the in-flight result must not change
    if (!id) begin
      i_req0_valid = 1'b0; i_req0_a = ~a; i_req0_b = ~b; i_req0_sub = ~sub;
    end else begin
      i_req1_valid = 1'b0; i_req1_a = ~a; i_req1_b = ~b; i_req1_sub = ~sub;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !o_busy) break;
      tick();
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1 i_rst = 1'b1;
    i_req0_valid = 1'b1; i_req0_a = 16'h1234; i_req0_b = 16'h0FCD; i_req0_sub = 1'b0;
    i_req1_valid = 1'b1; i_req1_a = 16'h0005; i_req1_b = 16'h0007; i_req1_sub = 1'b1;
    #1;
    chk("rst_s", 32'(o_rsp_s), 32'd0);
    chk("rst_id", 32'(o_rsp_id), 32'd0);
    chk("rst_c", 32'(o_rsp_c), 32'd0);
    repeat (3) tick();

    // both requesters valid continuously after reset
    i_rst = 1'b0;
    for (int i = 0; i < 100 && grant_log.size() < 4; i++) tick();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    if (grant_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("grant_order", 32'(grant_log[i]), 32'(i % 2));
    end else begin
      chk("grant_count", 32'(grant_log.size()), 32'd4);
    end
    drain();

    send(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    drain();
    send(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    drain();
    send(1'b0, 16'h0005, 16'h0007, 1'b1);
    for (int i = 0; i < 8; i++)
      send(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    drain();

    // consumer stalls in DONE while requester 1 waits
    i_rsp_ready = 1'b0;
    send(1'b0, 16'h8000, 16'h8000, 1'b0);
    i_req1_valid = 1'b1; i_req1_a = 16'h4000; i_req1_b = 16'h4000; i_req1_sub = 1'b0;
    for (int i = 0; i < 20 && !o_rsp_valid; i++) tick();
    chk("done_reached", 32'(o_rsp_valid), 32'd1);
    repeat (3) tick();
    i_rsp_ready = 1'b1;
    tick();
    chk("idle_after_xfer", 32'(o_busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc1) break;
    end
    chk("bubble_accept", 32'(acc_cyc), 32'(xfer_cyc + 1));
    i_req1_valid = 1'b0;
    drain();

    // reset on the second RUN cycle aborts the operation
    send(1'b1, 16'h1111, 16'h2222, 1'b0);
    tick();
    chk("run2_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_rsp_valid", 32'(o_rsp_valid), 32'd0);
    tick();
    tick();
    i_rst = 1'b0;
    repeat (8) tick();
    send(1'b0, 16'h00FF, 16'h0001, 1'b0);
    drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_seq_arb.md
ADD_SEQ_ARB -- requirements
Module: add_seq_arb

Interface
REQ-001 Parameter NIBBLES, default 4, meaning operand width in 4-bit nibbles (W = 4*NIBBLES); legal range 1..8.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_req0_valid  input  1  requester 0 has an operation pending.
REQ-005 i_req0_a, i_req0_b  input  W each  requester 0 operands.
REQ-006 i_req0_sub  input  1  requester 0 op: 0 = a+b, 1 = a-b.
REQ-007 o_req0_ready  output  1  requester 0 operation accepted this cycle (transfer = valid & ready).
REQ-008 i_req1_valid, i_req1_a, i_req1_b, i_req1_sub, o_req1_ready  same widths and meaning as REQ-004..007, for requester 1.
REQ-009 o_rsp_valid  output  1  result available.
REQ-010 i_rsp_ready  input  1  consumer takes result (transfer = valid & ready).
REQ-011 o_rsp_id  output  1  requester index that owns the result.
REQ-012 o_rsp_s  output  W  sum/difference, modulo 2^W.
REQ-013 o_rsp_c  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 o_rsp_v  output  1  two's-complement signed overflow.
REQ-015 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Datapath SHALL be exactly one 4-bit carry-lookahead adder instance, time-shared across nibbles and requesters; no wider adder.
REQ-017 FSM states SHALL be IDLE, RUN, DONE.
REQ-018 IDLE: if any valid, assert ready to exactly one winner combinationally, latch its a, b^{W{sub}}, sub, id; go RUN; nibble counter = 0; carry register = sub.
REQ-019 Arbitration: round-robin; on simultaneous valid, grant the requester not granted last; after reset, requester 0 has priority.
REQ-020 Single valid SHALL be granted regardless of pointer; pointer updates only on grant.
REQ-021 Ready SHALL be 0 for both requesters in RUN and DONE; requests wait, no drop.
REQ-022 RUN: each cycle add nibble k of a, nibble k of b', carry register; write sum nibble k into result register; carry register <= adder carry out; k increments.
REQ-023 RUN SHALL last exactly NIBBLES cycles, nibble 0 first; after nibble NIBBLES-1 go DONE.
REQ-024 o_rsp_c = final carry register; o_rsp_v = (a[W-1] == b'[W-1]) & (s[W-1] != a[W-1]).
REQ-025 DONE: o_rsp_valid = 1; o_rsp_s/c/v/id stable until transfer; on transfer go IDLE.
REQ-026 Latency: accept at cycle T -> o_rsp_valid first high at T+NIBBLES+1.
REQ-027 No accept in the DONE-transfer cycle; next accept earliest one cycle later (one-cycle bubble).
REQ-028 o_rsp_valid SHALL be 0 in IDLE and RUN; o_rsp_s contents outside DONE are don't-care.
REQ-029 Requester inputs SHALL be sampled only at acceptance; later changes do not affect the in-flight result.

Reset
REQ-030 i_rst high SHALL immediately force IDLE, o_rsp_valid=0, o_req0_ready/o_req1_ready=0 while asserted, o_busy=0, counter=0, carry=0, result/id registers=0, RR pointer favouring requester 0.
REQ-031 Reset during RUN or DONE SHALL abort the operation; no response is produced for it.
REQ-032 First accept SHALL occur no earlier than the first rising edge after i_rst deasserts.

Verification
REQ-033 NIBBLES=4, req0 a=0x1234 b=0x0FCD sub=0 -> accept T, at T+5 rsp_valid, s=0x2201 c=0 v=0 id=0.
REQ-034 req1 a=0x0005 b=0x0007 sub=1 -> s=0xFFFE c=0 v=0 id=1; a=0x7FFF b=0x0001 sub=0 -> s=0x8000 c=0 v=1.
REQ-035 a=0xFFFF b=0x0001 sub=0 -> s=0x0000 c=1 v=0 (wrap-around).
REQ-036 After reset both valid continuously -> grants req0, req1, req0, req1; each ready one-cycle pulse; no double grant.
REQ-037 Hold i_rsp_ready=0 for 3 cycles in DONE -> outputs held stable, both ready=0; release -> IDLE next cycle, next accept the cycle after.
REQ-038 Assert i_rst on 2nd RUN cycle -> same cycle o_busy=0, o_rsp_valid stays 0, no response; next request after release completes normally.
